// File: rtl/mnacidpro_ctrl_if.sv
// rtl/mnacidpro_ctrl_if.sv - host command, run configuration and status bundle for the purification sequencer
interface mnacidpro_ctrl_if #(
  parameter int CNT_W  = 12,
  parameter int WASH_W = 3
);
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  strokes_load;
  logic [CNT_W-1:0]  strokes_mix;
  logic [CNT_W-1:0]  strokes_wash;
  logic [CNT_W-1:0]  strokes_elute;
  logic [WASH_W-1:0] n_wash;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [2:0]        state;

  modport master (
    output start, abort, strokes_load, strokes_mix, strokes_wash, strokes_elute, n_wash,
    input  busy, done, aborted, state
  );

  modport slave (
    input  start, abort, strokes_load, strokes_mix, strokes_wash, strokes_elute, n_wash,
    output busy, done, aborted, state
  );
endinterface

// File: rtl/mnacidpro_ctrl.sv
// rtl/mnacidpro_ctrl.sv - purification protocol sequencer driving valves and the 3-phase peristaltic pump
module mnacidpro_ctrl #(
  parameter int PUMP_DIV = 1000,
  parameter int CNT_W    = 12,
  parameter int WASH_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  mnacidpro_ctrl_if.slave  host,
  output logic             lysis_ctl,
  output logic             wash_ctl,
  output logic             elute_ctl,
  output logic             horiz_ctl,
  output logic             dead_end_ctl,
  output logic             loop_exit_ctl,
  output logic             bead_vtl_ctl,
  output logic             bead_trap_ctl,
  output logic             collection_ctl,
  output logic             vertical_ctl,
  output logic             pump1,
  output logic             pump2,
  output logic             pump3
);

  localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PUMP_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_MIX     = 3'd2,
    S_CAPTURE = 3'd3,
    S_WASH    = 3'd4,
    S_ELUTE   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t            cur_state;
  state_t            next_state;

  // configuration captured at start
  logic [CNT_W-1:0]  cfg_load;
  logic [CNT_W-1:0]  cfg_mix;
  logic [CNT_W-1:0]  cfg_wash;
  logic [CNT_W-1:0]  cfg_elute;
  logic [WASH_W-1:0] cfg_nwash;

  // live inputs while idle (the start edge must already see them), latched copy afterwards
  logic [CNT_W-1:0]  eff_load;
  logic [CNT_W-1:0]  eff_mix;
  logic [CNT_W-1:0]  eff_wash;
  logic [CNT_W-1:0]  eff_elute;
  logic [WASH_W-1:0] eff_nwash;

  logic [DIV_W-1:0]  div_cnt;
  logic [2:0]        step;
  logic [CNT_W-1:0]  stroke_cnt;
  logic [WASH_W-1:0] pass_cnt;
  logic [WASH_W:0]   pass_done_cnt;

  logic              idle;
  logic              pumping;
  logic              stroke_end;
  logic              phase_last;
  logic              pass_more;
  logic              reload;
  logic              pass_next;
  logic              take_abort;
  logic              aborted_q;

  // First phase at or after s that actually has work; zero-length phases fall through in one edge
  function automatic state_t skip_from(input state_t s,
                                       input logic [CNT_W-1:0] ld, input logic [CNT_W-1:0] mx,
                                       input logic [CNT_W-1:0] ws, input logic [CNT_W-1:0] el,
                                       input logic [WASH_W-1:0] nw);
    state_t r;
    r = s;
    if (r == S_LOAD    && ld == '0)              r = S_MIX;
    if (r == S_MIX     && mx == '0)              r = S_CAPTURE;
    if (r == S_CAPTURE && ld == '0)              r = S_WASH;
    if (r == S_WASH    && (ws == '0 || nw == '0)) r = S_ELUTE;
    if (r == S_ELUTE   && el == '0)              r = S_DONE;
    return r;
  endfunction

  function automatic state_t phase_after(input state_t s);
    case (s)
      S_LOAD:    return S_MIX;
      S_MIX:     return S_CAPTURE;
      S_CAPTURE: return S_WASH;
      S_WASH:    return S_ELUTE;
      default:   return S_DONE;
    endcase
  endfunction

  // Capture reuses the load stroke count (same lysate volume pushed over the beads)
  function automatic logic [CNT_W-1:0] strokes_of(input state_t s,
                                                  input logic [CNT_W-1:0] ld, input logic [CNT_W-1:0] mx,
                                                  input logic [CNT_W-1:0] ws, input logic [CNT_W-1:0] el);
    case (s)
      S_LOAD, S_CAPTURE: return ld;
      S_MIX:             return mx;
      S_WASH:            return ws;
      S_ELUTE:           return el;
      default:           return '0;
    endcase
  endfunction

  assign idle      = (cur_state == S_IDLE);
  assign eff_load  = idle ? host.strokes_load  : cfg_load;
  assign eff_mix   = idle ? host.strokes_mix   : cfg_mix;
  assign eff_wash  = idle ? host.strokes_wash  : cfg_wash;
  assign eff_elute = idle ? host.strokes_elute : cfg_elute;
  assign eff_nwash = idle ? host.n_wash        : cfg_nwash;

  assign pumping       = (cur_state >= S_LOAD) && (cur_state <= S_ELUTE);
  assign stroke_end    = pumping && (div_cnt == DIV_LAST) && (step == 3'd5);
  assign phase_last    = stroke_end && (stroke_cnt <= CNT_W'(1));
  assign pass_done_cnt = {1'b0, pass_cnt} + (WASH_W+1)'(1);
  assign pass_more     = pass_done_cnt < {1'b0, cfg_nwash};

  // Next-state selection: start, phase completion with skip chaining, wash repeats, abort
  always_comb begin
    next_state = cur_state;
    reload     = 1'b0;
    pass_next  = 1'b0;
    take_abort = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (host.start) begin
          next_state = skip_from(S_LOAD, eff_load, eff_mix, eff_wash, eff_elute, eff_nwash);
          reload     = 1'b1;
        end
      end
      S_LOAD, S_MIX, S_CAPTURE, S_WASH, S_ELUTE: begin
        if (host.abort) begin
          take_abort = 1'b1;
          next_state = S_IDLE;
          reload     = 1'b1;
        end else if (phase_last) begin
          reload = 1'b1;
          if (cur_state == S_WASH && pass_more) begin
            pass_next = 1'b1;
          end else begin
            next_state = skip_from(phase_after(cur_state), eff_load, eff_mix, eff_wash, eff_elute, eff_nwash);
          end
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: begin
        next_state = S_IDLE;
        reload     = 1'b1;
      end
    endcase
  end

  // State register, run configuration latch and the one-cycle abort acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_IDLE;
      aborted_q <= 1'b0;
      cfg_load  <= '0;
      cfg_mix   <= '0;
      cfg_wash  <= '0;
      cfg_elute <= '0;
      cfg_nwash <= '0;
    end else begin
      cur_state <= next_state;
      aborted_q <= take_abort;
      if (idle && host.start) begin
        cfg_load  <= host.strokes_load;
        cfg_mix   <= host.strokes_mix;
        cfg_wash  <= host.strokes_wash;
        cfg_elute <= host.strokes_elute;
        cfg_nwash <= host.n_wash;
      end
    end
  end

  // Pump step divider, stroke countdown and wash pass counter; all restart on every phase/pass entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      step       <= 3'd0;
      stroke_cnt <= '0;
      pass_cnt   <= '0;
    end else if (reload) begin
      div_cnt    <= '0;
      step       <= 3'd0;
      stroke_cnt <= strokes_of(next_state, eff_load, eff_mix, eff_wash, eff_elute);
      pass_cnt   <= pass_next ? pass_done_cnt[WASH_W-1:0] : '0;
    end else if (pumping) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        if (step == 3'd5) begin
          step <= 3'd0;
          if (stroke_cnt != '0) stroke_cnt <= stroke_cnt - CNT_W'(1);
        end else begin
          step <= step + 3'd1;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Valve and pump decode; 1 = pressurised = closed, so everything defaults shut
  always_comb begin
    lysis_ctl      = 1'b1;
    wash_ctl       = 1'b1;
    elute_ctl      = 1'b1;
    horiz_ctl      = 1'b1;
    dead_end_ctl   = 1'b1;
    loop_exit_ctl  = 1'b1;
    bead_vtl_ctl   = 1'b1;
    bead_trap_ctl  = 1'b1;
    collection_ctl = 1'b1;
    vertical_ctl   = 1'b1;
    {pump1, pump2, pump3} = 3'b111;
    case (cur_state)
      S_LOAD: begin
        lysis_ctl    = 1'b0;
        horiz_ctl    = 1'b0;
        dead_end_ctl = 1'b0;
      end
      S_MIX: begin
        horiz_ctl    = 1'b0;
        vertical_ctl = 1'b0;
      end
      S_CAPTURE: begin
        bead_vtl_ctl  = 1'b0;
        loop_exit_ctl = 1'b0;
      end
      S_WASH: begin
        wash_ctl      = 1'b0;
        bead_vtl_ctl  = 1'b0;
        loop_exit_ctl = 1'b0;
      end
      S_ELUTE: begin
        elute_ctl      = 1'b0;
        bead_trap_ctl  = 1'b0;
        collection_ctl = 1'b0;
      end
      default: ;
    endcase
    if (pumping) begin
      case (step)
        3'd0:    {pump1, pump2, pump3} = 3'b011;
        3'd1:    {pump1, pump2, pump3} = 3'b001;
        3'd2:    {pump1, pump2, pump3} = 3'b101;
        3'd3:    {pump1, pump2, pump3} = 3'b100;
        3'd4:    {pump1, pump2, pump3} = 3'b110;
        3'd5:    {pump1, pump2, pump3} = 3'b010;
        default: {pump1, pump2, pump3} = 3'b111;
      endcase
    end
  end

  assign host.busy    = !idle;
  assign host.done    = (cur_state == S_DONE);
  assign host.aborted = aborted_q;
  assign host.state   = cur_state;

endmodule
